// File: rtl/sport_cmp_sched.sv
// Round-robin scheduler sharing one combinational companding compressor between
// the SPORT0 and SPORT1 transmit paths, with a programmable settle time before capture.
module sport_cmp_sched #(
    parameter int SETTLE = 1,
    parameter int CNTW   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        alaw0,
    output logic        ack0,
    output logic [7:0]  log0,
    input  logic        req1,
    input  logic [15:0] data1,
    input  logic        alaw1,
    output logic        ack1,
    output logic [7:0]  log1,
    output logic [15:0] cmp_tx,
    output logic        cmp_alaw,
    input  logic [7:0]  cmp_log,
    output logic        busy,
    output logic        gnt_id
);

    typedef enum logic [1:0] {IDLE, WAIT, CAP} state_t;

    state_t            r_state;
    logic              r_prio;
    logic [CNTW-1:0]   r_cnt;
    logic [15:0]       r_cmpTx;
    logic              r_cmpAlaw;
    logic              r_gnt;
    logic              r_ack0;
    logic              r_ack1;
    logic [7:0]        r_log0;
    logic [7:0]        r_log1;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant;
    logic              w_sel;

    // A requester acknowledged last cycle is masked so it cannot be re-granted in its ack cycle.
    assign w_elig0 = req0 & ~r_ack0;
    assign w_elig1 = req1 & ~r_ack1;
    assign w_grant = w_elig0 | w_elig1;
    assign w_sel   = (w_elig0 & w_elig1) ? r_prio : w_elig1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_prio    <= 1'b0;
            r_cnt     <= '0;
            r_cmpTx   <= 16'h0000;
            r_cmpAlaw <= 1'b0;
            r_gnt     <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_log0    <= 8'h00;
            r_log1    <= 8'h00;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_cmpTx   <= w_sel ? data1 : data0;
                        r_cmpAlaw <= w_sel ? alaw1 : alaw0;
                        r_gnt     <= w_sel;
                        r_prio    <= ~w_sel;
                        r_cnt     <= CNTW'(SETTLE);
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNTW'(1);
                    if (r_cnt == CNTW'(1)) begin
                        r_state <= CAP;
                    end
                end
                CAP: begin
                    if (r_gnt) begin
                        r_log1 <= cmp_log;
                        r_ack1 <= 1'b1;
                    end else begin
                        r_log0 <= cmp_log;
                        r_ack0 <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign log0     = r_log0;
    assign log1     = r_log1;
    assign cmp_tx   = r_cmpTx;
    assign cmp_alaw = r_cmpAlaw;
    assign busy     = (r_state != IDLE);
    assign gnt_id   = r_gnt;

endmodule

// File: tb/tb_sport_cmp_sched.sv
// Bench for sport_cmp_sched: G.711 compressor stand-in, transaction-level reference
// model checked every cycle, plus directed latency/fairness/reset scenarios.
module tb_sport_cmp_sched;

    localparam int SETTLE_A = 1;
    localparam int SETTLE_B = 15;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        req0, alaw0, req1, alaw1;
    logic [15:0] data0, data1;
    logic        ack0, ack1, cmpAlaw, busy, gntId;
    logic [7:0]  log0, log1, cmpLog;
    logic [15:0] cmpTx;

    logic        rstB, reqB, alawB, zeroB;
    logic [15:0] dataB, zeroDataB;
    logic        ackB0, ackB1, cmpAlawB, busyB, gntB;
    logic [7:0]  logB0, logB1, cmpLogB;
    logic [15:0] cmpTxB;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a transaction in flight completes SETTLE+1 edges after its grant.
    int          mRemain;
    logic        mGnt, mPrio, mAlaw, mAck0, mAck1;
    logic [15:0] mTx;
    logic [7:0]  mLog0, mLog1;

    logic        prevBusy = 1'b0;
    logic        grantQ[$];

    function automatic logic [7:0] g711(input logic [15:0] lin, input logic aLaw);
        int pcm;
        int seg;
        int mask;
        int v;
        pcm = int'($signed(lin));
        seg = 8;
        if (aLaw) begin
            pcm = pcm >>> 3;
            if (pcm >= 0) mask = 'hD5;
            else begin
                mask = 'h55;
                pcm  = -pcm - 1;
            end
            for (int i = 0; i < 8; i++) if (seg == 8 && pcm <= ((32 << i) - 1)) seg = i;
            if (seg >= 8) v = 'h7F ^ mask;
            else begin
                v = seg << 4;
                if (seg < 2) v = v | ((pcm >> 1) & 'hF);
                else         v = v | ((pcm >> seg) & 'hF);
                v = v ^ mask;
            end
        end else begin
            pcm = pcm >>> 2;
            if (pcm < 0) begin
                pcm  = -pcm;
                mask = 'h7F;
            end else mask = 'hFF;
            if (pcm > 8159) pcm = 8159;
            pcm = pcm + 'h21;
            for (int i = 0; i < 8; i++) if (seg == 8 && pcm <= ((64 << i) - 1)) seg = i;
            if (seg >= 8) v = 'h7F ^ mask;
            else          v = ((seg << 4) | ((pcm >> (seg + 1)) & 'hF)) ^ mask;
        end
        return v[7:0];
    endfunction

    assign cmpLog  = g711(cmpTx, cmpAlaw);
    assign cmpLogB = g711(cmpTxB, cmpAlawB);

    sport_cmp_sched #(.SETTLE(SETTLE_A), .CNTW(4)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .data0(data0), .alaw0(alaw0), .ack0(ack0), .log0(log0),
        .req1(req1), .data1(data1), .alaw1(alaw1), .ack1(ack1), .log1(log1),
        .cmp_tx(cmpTx), .cmp_alaw(cmpAlaw), .cmp_log(cmpLog),
        .busy(busy), .gnt_id(gntId)
    );

    sport_cmp_sched #(.SETTLE(SETTLE_B), .CNTW(4)) dutB (
        .CLK(CLK), .RST(rstB),
        .req0(reqB), .data0(dataB), .alaw0(alawB), .ack0(ackB0), .log0(logB0),
        .req1(zeroB), .data1(zeroDataB), .alaw1(zeroB), .ack1(ackB1), .log1(logB1),
        .cmp_tx(cmpTxB), .cmp_alaw(cmpAlawB), .cmp_log(cmpLogB),
        .busy(busyB), .gnt_id(gntB)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("ack0",     16'(ack0),    16'(mAck0));
        check("ack1",     16'(ack1),    16'(mAck1));
        check("log0",     16'(log0),    16'(mLog0));
        check("log1",     16'(log1),    16'(mLog1));
        check("busy",     16'(busy),    16'(mRemain != 0));
        check("gnt_id",   16'(gntId),   16'(mGnt));
        check("cmp_tx",   cmpTx,        mTx);
        check("cmp_alaw", 16'(cmpAlaw), 16'(mAlaw));
    endtask

    task automatic modelEdge();
        logic e0, e1, n;
        if (RST) begin
            mRemain = 0; mGnt = 0; mPrio = 0; mTx = 16'h0000; mAlaw = 0;
            mAck0 = 0; mAck1 = 0; mLog0 = 8'h00; mLog1 = 8'h00;
        end else if (mRemain == 0) begin
            e0 = req0 && !mAck0;
            e1 = req1 && !mAck1;
            mAck0 = 0;
            mAck1 = 0;
            if (e0 || e1) begin
                n       = (e0 && e1) ? mPrio : e1;
                mGnt    = n;
                mPrio   = !n;
                mTx     = n ? data1 : data0;
                mAlaw   = n ? alaw1 : alaw0;
                mRemain = SETTLE_A + 1;
            end
        end else begin
            mAck0 = 0;
            mAck1 = 0;
            mRemain--;
            if (mRemain == 0) begin
                if (mGnt) begin mLog1 = g711(mTx, mAlaw); mAck1 = 1; end
                else      begin mLog0 = g711(mTx, mAlaw); mAck0 = 1; end
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge CLK);
        modelEdge();
        #1;
        cyc++;
        checkOutput();
        if (busy === 1'b1 && prevBusy === 1'b0) grantQ.push_back(gntId);
        prevBusy = busy;
    endtask

    task automatic runUntilIdle(input int maxCycles);
        int n;
        n = 0;
        while ((mRemain != 0 || mAck0 || mAck1 || busy !== 1'b0) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        check("idle_timeout", 16'(n < maxCycles), 16'(1));
    endtask

    initial begin
        RST = 1; req0 = 1; req1 = 1; data0 = 16'h1234; data1 = 16'hABCD; alaw0 = 0; alaw1 = 1;
        rstB = 1; reqB = 0; dataB = 16'h0000; alawB = 0; zeroB = 0; zeroDataB = 16'h0000;
        $display("[TB] reset with both requests held");
        repeat (3) applyStimulus();
        check("rst_ack0", 16'(ack0), 16'(0));
        check("rst_busy", 16'(busy), 16'(0));
        RST = 0;
        grantQ.delete();
        repeat (8) applyStimulus();
        req0 = 0; req1 = 0;
        runUntilIdle(20);
        check("first_gnt", 16'(grantQ.size() >= 2 ? grantQ[0] : 1'bx), 16'(0));
        check("second_gnt", 16'(grantQ.size() >= 2 ? grantQ[1] : 1'bx), 16'(1));

        $display("[TB] single mu-law request, latency and ack masking");
        req0 = 1; data0 = 16'h0000; alaw0 = 0;
        applyStimulus();
        check("lat_busy1", 16'(busy), 16'(1));
        applyStimulus();
        check("lat_busy2", 16'(busy), 16'(1));
        applyStimulus();
        check("lat_ack0", 16'(ack0), 16'(1));
        check("lat_log0", 16'(log0), 16'(8'hFF));
        applyStimulus();
        check("no_regrant_in_ack", 16'(busy), 16'(0));
        req0 = 0;
        runUntilIdle(20);

        $display("[TB] single A-law request on SPORT1");
        req1 = 1; data1 = 16'h0000; alaw1 = 1;
        repeat (3) applyStimulus();
        check("alaw_ack1", 16'(ack1), 16'(1));
        check("alaw_log1", 16'(log1), 16'(8'hD5));
        check("alaw_log0_kept", 16'(log0), 16'(8'hFF));
        req1 = 0;
        runUntilIdle(20);

        $display("[TB] both held, alternating grants");
        grantQ.delete();
        req0 = 1; req1 = 1; data0 = 16'h4000; alaw0 = 0; data1 = 16'hC000; alaw1 = 1;
        for (int k = 0; k < 40 && grantQ.size() < 6; k++) applyStimulus();
        check("fair_count", 16'(grantQ.size() >= 6), 16'(1));
        for (int k = 0; k < 6; k++)
            check("fair_gnt", 16'(k < grantQ.size() ? grantQ[k] : 1'bx), 16'(k % 2));
        req0 = 0; req1 = 0;
        runUntilIdle(20);

        $display("[TB] data change during WAIT");
        req0 = 1; data0 = 16'h0000; alaw0 = 0;
        applyStimulus();
        data0 = 16'h7FFF;
        repeat (2) applyStimulus();
        check("inflight_ack0", 16'(ack0), 16'(1));
        check("inflight_log0", 16'(log0), 16'(8'hFF));
        req0 = 0;
        runUntilIdle(20);

        $display("[TB] reset during WAIT");
        req0 = 1; data0 = 16'h1111; alaw0 = 0;
        applyStimulus();
        RST = 1;
        applyStimulus();
        check("abort_ack0", 16'(ack0), 16'(0));
        check("abort_log0", 16'(log0), 16'(0));
        RST = 0;
        repeat (3) applyStimulus();
        check("retry_ack0", 16'(ack0), 16'(1));
        check("retry_log0", 16'(log0), 16'(g711(16'h1111, 1'b0)));
        req0 = 0;
        runUntilIdle(20);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 3) != 0);
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            alaw0 = 1'($urandom_range(0, 1));
            alaw1 = 1'($urandom_range(0, 1));
            RST   = ($urandom_range(0, 59) == 0);
            applyStimulus();
        end
        RST = 0; req0 = 0; req1 = 0;
        runUntilIdle(20);

        $display("[TB] long settle instance");
        rstB = 0;
        applyStimulus();
        reqB = 1; dataB = 16'h2345; alawB = 1;
        for (int k = 1; k <= 17; k++) begin
            applyStimulus();
            dataB = 16'($urandom);
            check("b_busy", 16'(busyB), 16'(k <= 16));
            check("b_ack0", 16'(ackB0), 16'(k == 17));
            if (k <= 16) check("b_cmp_tx", cmpTxB, 16'h2345);
        end
        check("b_log0", 16'(logB0), 16'(g711(16'h2345, 1'b1)));
        reqB = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
